mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single physical memory port (DPI pmem backend) between instruction fetch (IFU) and load/store (LSU).
//  Sits between core and memory model; replaces the direct always-on DPI calls in the core top.
//  Accepts one transaction at a time, forwards it with a valid/ready handshake, routes the response back to its owner.
// PARAMETERS
//  ADDR_W   64   address width, bytes
//  DATA_W   64   data width
//  MASK_W   8    write byte-mask width (DATA_W/8)
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  ifu_req     in   1       IFU read request (level)
//  ifu_addr    in   ADDR_W  IFU read address
//  ifu_gnt     out  1       1-cycle pulse: IFU request accepted, fields latched
//  ifu_rvalid  out  1       1-cycle pulse: ifu_rdata valid
//  ifu_rdata   out  DATA_W  read data
//  lsu_req     in   1       LSU request (level)
//  lsu_we      in   1       1=write, 0=read
//  lsu_addr    in   ADDR_W  LSU address
//  lsu_wdata   in   DATA_W  write data
//  lsu_wmask   in   MASK_W  write byte enables
//  lsu_gnt     out  1       1-cycle pulse: LSU request accepted
//  lsu_rvalid  out  1       1-cycle pulse: read data / write ack
//  lsu_rdata   out  DATA_W  read data (0 on write ack)
//  mem_valid   out  1       request to memory; held until mem_ready
//  mem_ready   in   1       memory accepts request this cycle
//  mem_we      out  1       write enable
//  mem_addr    out  ADDR_W  address
//  mem_wdata   out  DATA_W  write data
//  mem_wmask   out  MASK_W  byte mask (0 on reads)
//  mem_rvalid  in   1       response (read data or write ack)
//  mem_rdata   in   DATA_W  read data
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, owner cleared, rr pointer -> IFU-preferred; in-flight transaction discarded.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//  - IDLE: if any req, pick winner, pulse its *_gnt, latch addr/we/wdata/wmask (IFU: we=0, mask=0); next REQ.
//  - REQ: mem_valid=1, fields stable from latch. mem_ready=1 -> RESP; mem_ready&mem_rvalid same cycle -> complete.
//  - RESP: wait mem_rvalid; then 1-cycle owner *_rvalid with registered mem_rdata; next IDLE.
//  - Complete = owner *_rvalid pulse the cycle after mem_rvalid seen. Min latency req->rvalid: 3 cycles.
//  - Owner rvalid + IDLE: new request may be granted in the cycle after rvalid (no back-to-back grant in same cycle).
//  - Requester dropping req after gnt: ignored, transaction completes. Changing fields after gnt: ignored.
//  - mem_rvalid in IDLE or REQ-without-ready: ignored (protocol error, no state change).
//  - Non-owner rvalid stays 0; *_rdata holds last value, only meaningful with rvalid.
//  - Arbitration (default): fixed priority, LSU wins ties; IFU may starve under continuous LSU req.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; on a tie the requester not served last wins; rr pointer updates on gnt.
//  MEM_ARB_RR_EN undefined: fixed LSU priority as above, no pointer flop.
// STRUCTURE
//  mem_arb_pkg: state enum {IDLE,REQ,RESP}, owner enum {OWN_IFU,OWN_LSU}, ADDR_W/DATA_W defaults.
//  Sub-module mem_arb_pick: combinational winner select (fixed / rr via macro), inputs reqs + last owner.
//  Datapath latch + FSM in mem_arbiter.
// TESTING
//  1 IFU read 0x8000_0000, mem_ready at once, rvalid 1 cycle later rdata=0x13 -> ifu_gnt, ifu_rvalid, ifu_rdata=0x13.
//  2 LSU write addr 0x8000_0100 wdata 0xDEAD mask 0xFF, mem_ready delayed 3 cycles -> mem_* stable, lsu_rvalid after ack.
//  3 ifu_req & lsu_req same cycle, no macro -> LSU granted first, IFU next; with MEM_ARB_RR_EN: alternate IFU/LSU.
//  4 rst asserted in RESP -> next cycle all outputs 0, IDLE; later mem_rvalid yields no *_rvalid.
//  5 mem_ready & mem_rvalid same cycle in REQ, rdata=0x55 -> owner rvalid next cycle, rdata=0x55, back to IDLE.
//  6 IFU drops req after gnt, addr changes -> mem_addr keeps latched value, ifu_rvalid still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encodings, owner type and latched request payload for mem_arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_if.sv
// Core-side (IFU/LSU) and memory-side signal bundle of mem_arbiter.
// slave = arbiter view, master = environment (core + memory model) view.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU.
// MEM_ARB_RR_EN: round-robin on the last owner; otherwise fixed LSU priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  owner_t last,
`endif
    input  logic   ifu_req,
    input  logic   lsu_req,
    output logic   any_c,
    output owner_t win_c
);

    always_comb begin
        any_c = ifu_req | lsu_req;
        win_c = lsu_req ? OWN_LSU : OWN_IFU;
`ifdef MEM_ARB_RR_EN
        // on a tie, serve whoever was not granted last
        if (ifu_req && lsu_req) begin
            win_c = (last == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction in flight, response routed to its owner.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    logic [1:0]        state_q, state_d;
    owner_t            owner_q, owner_d;
    mem_req_t          req_q, req_d;
    logic              mem_valid_q, mem_valid_d;
    logic              ifu_gnt_q, ifu_gnt_d;
    logic              lsu_gnt_q, lsu_gnt_d;
    logic              ifu_rvalid_q, ifu_rvalid_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              complete_c;
    logic              any_c;
    owner_t            win_c;

`ifdef MEM_ARB_RR_EN
    owner_t last_q;

    // reset to "LSU served last" so the first tie goes to IFU
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_LSU;
        end else if (state_q == ST_IDLE && any_c) begin
            last_q <= win_c;
        end
    end
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .last    (last_q),
`endif
        .ifu_req (bus.ifu_req),
        .lsu_req (bus.lsu_req),
        .any_c   (any_c),
        .win_c   (win_c)
    );

    // next state, request latch and registered outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        mem_valid_d  = mem_valid_q;
        ifu_gnt_d    = 1'b0;
        lsu_gnt_d    = 1'b0;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        complete_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    owner_d     = win_c;
                    mem_valid_d = 1'b1;
                    state_d     = ST_REQ;
                    if (win_c == OWN_LSU) begin
                        lsu_gnt_d   = 1'b1;
                        req_d.we    = bus.lsu_we;
                        req_d.addr  = bus.lsu_addr;
                        req_d.wdata = bus.lsu_we ? bus.lsu_wdata : '0;
                        req_d.wmask = bus.lsu_we ? bus.lsu_wmask : '0;
                    end else begin
                        ifu_gnt_d   = 1'b1;
                        req_d.we    = 1'b0;
                        req_d.addr  = bus.ifu_addr;
                        req_d.wdata = '0;
                        req_d.wmask = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    complete_c  = bus.mem_rvalid;
                    state_d     = bus.mem_rvalid ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.mem_rvalid) begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        if (complete_c) begin
            if (owner_q == OWN_IFU) begin
                ifu_rvalid_d = 1'b1;
                ifu_rdata_d  = bus.mem_rdata;
            end else begin
                lsu_rvalid_d = 1'b1;
                lsu_rdata_d  = req_q.we ? '0 : bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            req_q        <= '0;
            mem_valid_q  <= 1'b0;
            ifu_gnt_q    <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            mem_valid_q  <= mem_valid_d;
            ifu_gnt_q    <= ifu_gnt_d;
            lsu_gnt_q    <= lsu_gnt_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign bus.ifu_gnt    = ifu_gnt_q;
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.lsu_gnt    = lsu_gnt_q;
    assign bus.lsu_rvalid = lsu_rvalid_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = req_q.we;
    assign bus.mem_addr   = req_q.addr;
    assign bus.mem_wdata  = req_q.wdata;
    assign bus.mem_wmask  = req_q.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus tie, reset and hold sequences.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          lsu;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          ready_dly;
        int          rv_dly;
        bit          spurious;
        logic [63:0] mem_rdata;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] gnt_code();
        return 64'({bus.lsu_gnt, bus.ifu_gnt});
    endfunction

    function automatic logic [63:0] rv_code();
        return 64'({bus.lsu_rvalid, bus.ifu_rvalid});
    endfunction

    task automatic idle_inputs();
        bus.ifu_req    = 1'b0;
        bus.ifu_addr   = '0;
        bus.lsu_req    = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_wdata  = '0;
        bus.lsu_wmask  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic wait_gnt(input bit lsu, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (bus.ifu_gnt || bus.lsu_gnt) seen = 1'b1;
        end
        check(name, gnt_code(), lsu ? 64'd2 : 64'd1);
    endtask

    // ready and rvalid in the same REQ cycle, then sample the owner pulse
    task automatic finish_now(input logic [63:0] rdata);
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        logic [63:0] code = v.lsu ? 64'd2 : 64'd1;
        if (v.lsu) begin
            bus.lsu_req   = 1'b1;
            bus.lsu_we    = v.we;
            bus.lsu_addr  = v.addr;
            bus.lsu_wdata = v.wdata;
            bus.lsu_wmask = v.wmask;
        end else begin
            bus.ifu_req  = 1'b1;
            bus.ifu_addr = v.addr;
        end
        wait_gnt(v.lsu, $sformatf("v%0d_gnt", idx));
        // requester walks away and scrambles its fields; latched copy must win
        bus.ifu_req   = 1'b0;
        bus.lsu_req   = 1'b0;
        bus.ifu_addr  = ~v.addr;
        bus.lsu_addr  = ~v.addr;
        bus.lsu_we    = ~v.we;
        bus.lsu_wdata = ~v.wdata;
        bus.lsu_wmask = ~v.wmask;
        check($sformatf("v%0d_mem_valid", idx), 64'(bus.mem_valid), 64'd1);
        check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
        check($sformatf("v%0d_mem_we", idx), 64'(bus.mem_we), 64'(v.we));
        check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
        check($sformatf("v%0d_mem_wmask", idx), 64'(bus.mem_wmask), 64'(v.exp_wmask));
        for (int d = 0; d < v.ready_dly; d++) begin
            if (v.spurious && d == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 64'hBAD0_BAD0;
            end
            step();
            bus.mem_rvalid = 1'b0;
            check($sformatf("v%0d_wait_rvalid", idx), rv_code(), 64'd0);
            check($sformatf("v%0d_wait_valid", idx), 64'(bus.mem_valid), 64'd1);
            check($sformatf("v%0d_wait_addr", idx), bus.mem_addr, v.addr);
        end
        if (v.rv_dly == 0) begin
            finish_now(v.mem_rdata);
        end else begin
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
            check($sformatf("v%0d_valid_drop", idx), 64'(bus.mem_valid), 64'd0);
            for (int k = 1; k < v.rv_dly; k++) step();
            check($sformatf("v%0d_resp_rvalid", idx), rv_code(), 64'd0);
            finish_now(v.mem_rdata);
        end
        check($sformatf("v%0d_rvalid", idx), rv_code(), code);
        check($sformatf("v%0d_rdata", idx), v.lsu ? bus.lsu_rdata : bus.ifu_rdata, v.exp_rdata);
        step();
        check($sformatf("v%0d_rvalid_pulse", idx), rv_code(), 64'd0);
        check($sformatf("v%0d_idle_valid", idx), 64'(bus.mem_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          first_lsu;
        logic [63:0] first_code;
        logic [63:0] second_code;

        //          lsu  we   addr                   wdata                  wmask  rdy rv  spur mem_rdata              exp_wdata              exp_wm exp_rdata
        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                 8'h00, 0,  1,  1'b0, 64'h13,                64'h0,                 8'h00, 64'h13};
        vecs[1] = '{1'b1, 1'b1, 64'h0000_0000_8000_0100, 64'hDEAD,              8'hFF, 3,  1,  1'b0, 64'h77,                64'hDEAD,              8'hFF, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 64'h0000_0000_8000_0200, 64'h1234,              8'h0F, 1,  2,  1'b0, 64'hCAFE_F00D,         64'h0,                 8'h00, 64'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'h0,                 8'h00, 0,  0,  1'b0, 64'h55,                64'h0,                 8'h00, 64'h55};
        vecs[4] = '{1'b1, 1'b0, 64'h0000_0000_8000_0300, 64'h0,                 8'h00, 2,  0,  1'b1, 64'h55AA,              64'h0,                 8'h00, 64'h55AA};
        vecs[5] = '{1'b1, 1'b1, 64'h0000_0000_8000_0308, 64'h0123_4567_89AB_CDEF, 8'h3C, 0, 3,  1'b0, 64'hFFFF,              64'h0123_4567_89AB_CDEF, 8'h3C, 64'h0};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_ctrl", 64'({bus.ifu_gnt, bus.lsu_gnt, bus.ifu_rvalid, bus.lsu_rvalid, bus.mem_valid, bus.mem_we}), 64'd0);
        check("reset_addr", bus.mem_addr, 64'd0);
        check("reset_rdata", bus.ifu_rdata | bus.lsu_rdata, 64'd0);

        // simultaneous requests straight out of reset
`ifdef MEM_ARB_RR_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif
        first_code  = first_lsu ? 64'd2 : 64'd1;
        second_code = first_lsu ? 64'd1 : 64'd2;
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 64'h1000;
        bus.lsu_req  = 1'b1;
        bus.lsu_addr = 64'h2000;
        step();
        check("tie1_gnt", gnt_code(), first_code);
        check("tie1_addr", bus.mem_addr, first_lsu ? 64'h2000 : 64'h1000);
        if (first_lsu) bus.lsu_req = 1'b0;
        else           bus.ifu_req = 1'b0;
        finish_now(64'h11);
        check("tie1_rvalid", rv_code(), first_code);
        check("tie1_no_gnt_with_rvalid", gnt_code(), 64'd0);
        step();
        check("tie2_gnt", gnt_code(), second_code);
        check("tie2_addr", bus.mem_addr, first_lsu ? 64'h1000 : 64'h2000);
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        finish_now(64'h22);
        check("tie2_rvalid", rv_code(), second_code);
        bus.ifu_req = 1'b1;
        bus.lsu_req = 1'b1;
        step();
        check("tie3_gnt", gnt_code(), first_code);
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        finish_now(64'h33);
        check("tie3_rvalid", rv_code(), first_code);
        step();

        for (int i = 0; i < 6; i++) run_vec(i);
        check("ifu_rdata_hold", bus.ifu_rdata, 64'h55);

        // reset while waiting for the response
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 64'h4000;
        wait_gnt(1'b0, "rst_gnt");
        bus.ifu_req   = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_resp_ctrl", 64'({bus.ifu_gnt, bus.lsu_gnt, bus.ifu_rvalid, bus.lsu_rvalid, bus.mem_valid, bus.mem_we}), 64'd0);
        check("rst_resp_addr", bus.mem_addr, 64'd0);
        check("rst_resp_wmask", 64'(bus.mem_wmask), 64'd0);
        check("rst_resp_rdata", bus.ifu_rdata | bus.lsu_rdata, 64'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h99;
        step();
        bus.mem_rvalid = 1'b0;
        check("rst_late_rvalid", rv_code(), 64'd0);
        step();
        check("rst_late_rvalid2", rv_code(), 64'd0);
        check("rst_late_idle", 64'(bus.mem_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
